// File: rtl/oh_rrmux3.sv
// oh_rrmux3: 3-way round-robin arbiter with packet lock
// feeding a registered and-or-invert data mux.
module oh_rrmux3 #(
    parameter int DW  = 8,
    parameter bit PKT = 1'b1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [2:0]    in_valid,
    input  logic [2:0]    in_last,
    input  logic [DW-1:0] in0_data,
    input  logic [DW-1:0] in1_data,
    input  logic [DW-1:0] in2_data,
    output logic [2:0]    in_ready,
    output logic          out_valid,
    output logic          out_last,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src,
    input  logic          out_ready,
    output logic [2:0]    grant
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state;
    logic [1:0]    lock_id;
    logic [1:0]    ptr;
    logic          load;
    logic          xfer;
    logic [2:0]    lock_oh;
    logic [2:0]    elig;
    logic [2:0]    rr;
    logic [1:0]    win;
    logic          win_last;
    logic [DW-1:0] mux_n;

    assign load = ~out_valid | out_ready;

    always_comb begin
        lock_oh = 3'b000;
        case (lock_id)
            2'd0:    lock_oh = 3'b001;
            2'd1:    lock_oh = 3'b010;
            default: lock_oh = 3'b100;
        endcase
    end

    assign elig = (state == LOCKED) ? (in_valid & lock_oh) : in_valid;

    // Search starts just after the last winner.
    always_comb begin
        rr = 3'b000;
        case (ptr)
            2'd0: begin
                if (elig[1])      rr = 3'b010;
                else if (elig[2]) rr = 3'b100;
                else if (elig[0]) rr = 3'b001;
            end
            2'd1: begin
                if (elig[2])      rr = 3'b100;
                else if (elig[0]) rr = 3'b001;
                else if (elig[1]) rr = 3'b010;
            end
            default: begin
                if (elig[0])      rr = 3'b001;
                else if (elig[1]) rr = 3'b010;
                else if (elig[2]) rr = 3'b100;
            end
        endcase
    end

    assign grant    = (state == LOCKED) ? elig : rr;
    assign in_ready = grant & {3{load}};
    assign xfer     = |in_ready;
    assign win_last = |(in_last & grant);

    always_comb begin
        win = 2'd0;
        unique case (1'b1)
            grant[1]: win = 2'd1;
            grant[2]: win = 2'd2;
            default:  win = 2'd0;
        endcase
    end

    assign mux_n = ~((in0_data & {DW{grant[0]}}) |
                     (in1_data & {DW{grant[1]}}) |
                     (in2_data & {DW{grant[2]}}));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_last  <= PKT ? win_last : 1'b1;
            out_data  <= ~mux_n;
            out_src   <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            lock_id <= 2'd0;
            ptr     <= 2'd2;
        end else if (xfer) begin
            if (!PKT) begin
                ptr <= win;
            end else if (state == IDLE) begin
                if (win_last) begin
                    ptr <= win;
                end else begin
                    state   <= LOCKED;
                    lock_id <= win;
                end
            end else if (win_last) begin
                state <= IDLE;
                ptr   <= win;
            end
        end
    end

endmodule
